// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: CPU-side front end for an SPI memory engine.
// Holds a one-entry read buffer so that repeated reads of the same byte
// skip the SPI access. Writes go through to SPI and refresh the buffer.
// A WAIT that runs for TIMEOUT cycles without spi_done ends the
// transaction with err=1 and rdata=8'hFF.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for req; read hits are answered from the buffer
//   ISSUE | one-cycle spi_start pulse, timeout counter cleared
//   WAIT  | waiting for spi_done, counting toward TIMEOUT
//   RESP  | one-cycle ack, then back to IDLE
module spi_mem_ctrl #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        flush,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        err,
    output logic        spi_start,
    output logic        spi_write,
    output logic [15:0] spi_address,
    output logic [7:0]  spi_databus,
    input  logic        spi_done,
    input  logic [7:0]  spi_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Last counter value of the WAIT window; the window is TIMEOUT cycles long.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        buf_valid;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;
    logic        hit;
    logic        tmo;

    // A flush in the same cycle as the request forces a miss.
    assign hit = !we && buf_valid && (addr == buf_addr) && !flush;
    assign tmo = (cnt == CNT_LAST);

    // SPI request fields come straight from the request registers, which
    // only change on acceptance in IDLE, so they are stable through WAIT.
    assign spi_write   = r_we;
    assign spi_address = r_addr;
    assign spi_databus = r_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        spi_start = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    state_nxt = hit ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                spi_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (spi_done || tmo) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                ack       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Timeout counter: cleared in ISSUE, counts WAIT cycles without spi_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (state == S_ISSUE) begin
            cnt <= 8'd0;
        end else if (state == S_WAIT && !spi_done && !tmo) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Request registers, read buffer, rdata and err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_addr    <= 16'd0;
            r_wdata   <= 8'd0;
            buf_valid <= 1'b0;
            buf_addr  <= 16'd0;
            buf_data  <= 8'd0;
            rdata     <= 8'd0;
            err       <= 1'b0;
        end else begin
            if (state == S_IDLE && req) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                err     <= 1'b0;
                if (hit) begin
                    rdata <= buf_data;
                end
            end
            if (state == S_WAIT) begin
                // spi_done has priority over a coincident timeout.
                if (spi_done) begin
                    buf_addr  <= r_addr;
                    buf_valid <= 1'b1;
                    if (r_we) begin
                        buf_data <= r_wdata;
                    end else begin
                        buf_data <= spi_data;
                        rdata    <= spi_data;
                    end
                end else if (tmo) begin
                    err       <= 1'b1;
                    rdata     <= 8'hFF;
                    buf_valid <= 1'b0;
                end
            end
            // Last assignment wins, so flush beats a same-cycle completion.
            if (flush) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: one instance at the default TIMEOUT,
// a second at TIMEOUT=8 for the timeout path.
module tb_spi_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        req_t;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        flush;
    logic        spi_done;
    logic        spi_done_t;
    logic [7:0]  spi_data;

    logic        ack,         ack_t;
    logic [7:0]  rdata,       rdata_t;
    logic        busy,        busy_t;
    logic        err,         err_t;
    logic        spi_start,   spi_start_t;
    logic        spi_write,   spi_write_t;
    logic [15:0] spi_address, spi_address_t;
    logic [7:0]  spi_databus, spi_databus_t;

    int errors;
    int checks;
    int start_cnt;
    int ack_cnt;

    spi_mem_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .ack         (ack),
        .rdata       (rdata),
        .busy        (busy),
        .err         (err),
        .spi_start   (spi_start),
        .spi_write   (spi_write),
        .spi_address (spi_address),
        .spi_databus (spi_databus),
        .spi_done    (spi_done),
        .spi_data    (spi_data)
    );

    spi_mem_ctrl #(.TIMEOUT(8)) u_dut_t8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_t),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .ack         (ack_t),
        .rdata       (rdata_t),
        .busy        (busy_t),
        .err         (err_t),
        .spi_start   (spi_start_t),
        .spi_write   (spi_write_t),
        .spi_address (spi_address_t),
        .spi_databus (spi_databus_t),
        .spi_done    (spi_done_t),
        .spi_data    (spi_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the default instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (spi_start === 1'b1) start_cnt++;
        if (ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs depend only on
    // registers, so sampling here and then driving new inputs is race-free.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full SPI transaction on the default instance: spi_done is raised in
    // the wait_cyc-th WAIT cycle, optionally together with flush.
    task automatic run_miss(input string tag, input logic w, input logic [15:0] a,
                            input logic [7:0] d, input int wait_cyc,
                            input logic [7:0] sd, input logic fl);
        int s0;
        s0    = start_cnt;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        tick();
        req = 1'b0;
        chk({tag, "_start"}, spi_start, 1'b1);
        chk({tag, "_dir"}, spi_write, w);
        chk({tag, "_addr"}, spi_address, a);
        if (w) chk({tag, "_wdata"}, spi_databus, d);
        repeat (wait_cyc) tick();
        chk({tag, "_addr_stable"}, spi_address, a);
        chk({tag, "_no_early_ack"}, ack, 1'b0);
        spi_done = 1'b1;
        spi_data = sd;
        flush    = fl;
        tick();
        spi_done = 1'b0;
        flush    = 1'b0;
        chk({tag, "_ack"}, ack, 1'b1);
        if (!w) chk({tag, "_rdata"}, rdata, sd);
        tick();
        chk({tag, "_ack_one_cycle"}, ack, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_one_start"}, start_cnt - s0, 1);
    endtask

    // Read expected to hit the buffer: ack in the cycle after req is sampled.
    task automatic run_hit(input string tag, input logic [15:0] a, input logic [7:0] exp_d);
        int s0;
        s0   = start_cnt;
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        tick();
        req = 1'b0;
        chk({tag, "_ack"}, ack, 1'b1);
        chk({tag, "_rdata"}, rdata, exp_d);
        tick();
        chk({tag, "_no_start"}, start_cnt - s0, 0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        errors     = 0;
        checks     = 0;
        start_cnt  = 0;
        ack_cnt    = 0;
        rst_n      = 1'b0;
        req        = 1'b0;
        req_t      = 1'b0;
        we         = 1'b0;
        addr       = 16'h0;
        wdata      = 8'h0;
        flush      = 1'b0;
        spi_done   = 1'b0;
        spi_done_t = 1'b0;
        spi_data   = 8'h0;

        #2;
        chk("rst_ack",   ack,         1'b0);
        chk("rst_busy",  busy,        1'b0);
        chk("rst_err",   err,         1'b0);
        chk("rst_start", spi_start,   1'b0);
        chk("rst_write", spi_write,   1'b0);
        chk("rst_rdata", rdata,       8'h00);
        chk("rst_saddr", spi_address, 16'h0000);
        chk("rst_sdata", spi_databus, 8'h00);
        chk("rst_t8_busy", busy_t,    1'b0);

        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Miss read, then hit read of the same address.
        run_miss("miss_rd", 1'b0, 16'h1234, 8'h00, 66, 8'hA5, 1'b0);
        run_hit("hit_rd", 16'h1234, 8'hA5);

        // Write-through then hit on the written byte.
        run_miss("wr", 1'b1, 16'h0010, 8'h3C, 2, 8'h77, 1'b0);
        run_hit("wr_hit", 16'h0010, 8'h3C);

        // Flush with request on a buffered address forces an SPI access.
        flush = 1'b1;
        run_miss("flush_req", 1'b0, 16'h0010, 8'h00, 1, 8'h5A, 1'b0);

        // Flush with completion leaves the buffer invalid: next read misses.
        run_miss("flush_done", 1'b0, 16'h0020, 8'h00, 3, 8'hC3, 1'b1);
        run_miss("after_flush", 1'b0, 16'h0020, 8'h00, 1, 8'hC3, 1'b0);
        run_hit("refill_hit", 16'h0020, 8'hC3);

        // Requests while busy are ignored.
        req  = 1'b1;
        we   = 1'b0;
        addr = 16'h0030;
        tick();
        addr = 16'h0099;
        tick();
        tick();
        req = 1'b0;
        chk("busy_ign_addr", spi_address, 16'h0030);
        spi_done = 1'b1;
        spi_data = 8'h6E;
        tick();
        spi_done = 1'b0;
        chk("busy_ign_ack", ack, 1'b1);
        chk("busy_ign_rdata", rdata, 8'h6E);
        tick();
        chk("busy_ign_idle", busy, 1'b0);

        // spi_done in IDLE is ignored.
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        chk("idle_done_ack", ack, 1'b0);
        chk("idle_done_busy", busy, 1'b0);

        // Timeout on the TIMEOUT=8 instance: ISSUE, 8 WAIT cycles, then RESP.
        req_t = 1'b1;
        we    = 1'b0;
        addr  = 16'h0040;
        tick();
        req_t = 1'b0;
        chk("t8_start", spi_start_t, 1'b1);
        n = 0;
        while (ack_t !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t8_ack_seen", ack_t, 1'b1);
        chk("t8_latency", n, 9);
        chk("t8_err", err_t, 1'b1);
        chk("t8_rdata", rdata_t, 8'hFF);
        tick();
        spi_done_t = 1'b1;
        spi_data   = 8'h11;
        tick();
        spi_done_t = 1'b0;
        chk("t8_late_done_ack", ack_t, 1'b0);
        chk("t8_late_done_busy", busy_t, 1'b0);
        chk("t8_err_held", err_t, 1'b1);
        chk("t8_rdata_held", rdata_t, 8'hFF);

        // Re-read misses, clears err; done in the last WAIT cycle beats timeout.
        req_t = 1'b1;
        tick();
        req_t = 1'b0;
        chk("t8_reread_miss", spi_start_t, 1'b1);
        chk("t8_err_clear", err_t, 1'b0);
        repeat (8) tick();
        chk("t8_still_wait", busy_t & ~ack_t, 1'b1);
        spi_done_t = 1'b1;
        spi_data   = 8'h99;
        tick();
        spi_done_t = 1'b0;
        chk("t8_tie_ack", ack_t, 1'b1);
        chk("t8_tie_err", err_t, 1'b0);
        chk("t8_tie_rdata", rdata_t, 8'h99);
        tick();

        // Reset in WAIT of a write: everything drops immediately, no ack later.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 16'h0050;
        wdata = 8'h81;
        tick();
        req = 1'b0;
        tick();
        chk("rstw_pre_write", spi_write, 1'b1);
        ack_cnt = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_ack",   ack,         1'b0);
        chk("rstw_busy",  busy,        1'b0);
        chk("rstw_err",   err,         1'b0);
        chk("rstw_start", spi_start,   1'b0);
        chk("rstw_write", spi_write,   1'b0);
        chk("rstw_rdata", rdata,       8'h00);
        chk("rstw_saddr", spi_address, 16'h0000);
        chk("rstw_sdata", spi_databus, 8'h00);
        tick();
        rst_n    = 1'b1;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        tick();
        chk("rstw_no_ack", ack_cnt, 0);
        chk("rstw_idle", busy, 1'b0);

        // First rising edge after reset release accepts a request.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 16'h0060;
        tick();
        req = 1'b0;
        chk("rel_accept_busy", busy, 1'b1);
        chk("rel_accept_start", spi_start, 1'b1);
        tick();
        spi_done = 1'b1;
        spi_data = 8'h42;
        tick();
        spi_done = 1'b0;
        chk("rel_ack", ack, 1'b1);
        chk("rel_rdata", rdata, 8'h42);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
